// File: rtl/doublerate.sv
// doublerate: rate-doubling reorder buffer for the FFT datapath.
//
// Captures one half-rate sample per two clocks (the odd-cycle value) over a
// frame of N = 2^CBW cycles. In the second half of the following frame, it
// replays that frame's N/2 samples back-to-back at full rate. Two ping-pong
// banks let capture of frame f+1 overlap replay of frame f.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   cnt       frame cycle index, incremented by one every clock modulo N
//   din       half-rate sample; sample k is presented at cnt = 2k and 2k+1
//   dout      registered full-rate replayed sample (0 when not valid)
//   dout_vld  registered; high while dout carries a replayed sample

module doublerate #(
  parameter int DBW = 3,
  parameter int CBW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CBW-1:0] cnt,
  input  logic [DBW-1:0] din,
  output logic [DBW-1:0] dout,
  output logic           dout_vld
);

  localparam int HALF = 1 << (CBW - 1);   // samples per frame
  localparam int AW   = CBW - 1;          // bank address width

  localparam logic [CBW-1:0] CNT_LAST = CBW'((1 << CBW) - 1);
  localparam logic [CBW-1:0] RD_FIRST = CBW'(HALF - 1);
  localparam logic [CBW-1:0] RD_LAST  = CBW'((1 << CBW) - 2);
  localparam logic [AW-1:0]  RD_OFS   = AW'(HALF - 1);

  logic           wr_bank_reg;
  logic           armed_reg;
  logic           rd_ok_reg;
  logic [DBW-1:0] dout_reg;
  logic           dout_vld_reg;

  logic [AW-1:0]  wr_addr;
  logic [AW-1:0]  rd_addr;
  logic           wr_en;
  logic           rd_win;
  logic           swap;
  logic [DBW-1:0] bank_rd [2];

  // Sample k arrives at cnt 2k/2k+1, so the write address is cnt/2.
  assign wr_addr = cnt[CBW-1:1];
  // Read index j = cnt - (N/2-1). Since 0 <= j < N/2, the subtraction can be
  // done modulo N/2 on the low bits alone.
  assign rd_addr = cnt[AW-1:0] - RD_OFS;
  assign wr_en   = armed_reg & cnt[0];
  assign rd_win  = (cnt >= RD_FIRST) && (cnt <= RD_LAST);
  assign swap    = armed_reg && (cnt == CNT_LAST);

  // Two storage banks. The write side is synchronous with no reset, so it
  // maps onto RAM. Contents are never exposed until a full frame is captured.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [DBW-1:0] mem [HALF];

      always_ff @(posedge clk) begin
        if (wr_en && (wr_bank_reg == 1'(gi))) begin
          mem[wr_addr] <= din;
        end
      end

      assign bank_rd[gi] = mem[rd_addr];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_reg  <= 1'b0;
      armed_reg    <= 1'b0;
      rd_ok_reg    <= 1'b0;
      dout_reg     <= '0;
      dout_vld_reg <= 1'b0;
    end else begin
      // Only start capturing on a frame boundary. A partial frame that
      // follows reset is therefore never replayed.
      if (cnt == '0) begin
        armed_reg <= 1'b1;
      end

      // The last write of the frame (cnt = N-1) still lands in the old bank,
      // because the write logic sees the pre-toggle wr_bank_reg.
      if (swap) begin
        wr_bank_reg <= ~wr_bank_reg;
        rd_ok_reg   <= 1'b1;
      end

      // The read window ends at N-2, ahead of the toggle at N-1. Until a
      // complete frame exists, the bank contents are masked to zero.
      if (rd_win && rd_ok_reg) begin
        dout_reg     <= bank_rd[~wr_bank_reg];
        dout_vld_reg <= 1'b1;
      end else begin
        dout_reg     <= '0;
        dout_vld_reg <= 1'b0;
      end
    end
  end

  assign dout     = dout_reg;
  assign dout_vld = dout_vld_reg;

endmodule

// File: tb/tb_doublerate.sv
// tb_doublerate: scoreboard bench for doublerate.
// Instance a uses N=8, 3-bit data. Instance b uses N=16, 8-bit data.
// Inputs are driven on the falling edge. Outputs are checked on the falling
// edge just before the next input is driven. Each captured frame is pushed to
// a per-instance queue when its last cycle is driven. The replayed values are
// popped as the valid window is reached.

module tb_doublerate;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic [2:0] cnt_a = '0;
  logic [2:0] din_a = '0;
  logic [2:0] dout_a;
  logic       vld_a;
  logic       rst_b = 1'b1;
  logic [3:0] cnt_b = '0;
  logic [7:0] din_b = '0;
  logic [7:0] dout_b;
  logic       vld_b;

  int vectors     = 0;
  int miscompares = 0;

  // per-instance reference state
  int         cur_rst [2] = '{1, 1};
  int         cap_ok  [2] = '{0, 0};
  int         pending [2] = '{0, 0};
  int         ready   [2] = '{0, 0};
  logic [7:0] stage   [2][8];
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  logic [7:0] pat [8];

  doublerate #(.DBW(3), .CBW(3)) u_dut_a (
    .clk(clk), .rst(rst_a), .cnt(cnt_a), .din(din_a),
    .dout(dout_a), .dout_vld(vld_a)
  );

  doublerate #(.DBW(8), .CBW(4)) u_dut_b (
    .clk(clk), .rst(rst_b), .cnt(cnt_b), .din(din_b),
    .dout(dout_b), .dout_vld(vld_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus for instance sel. The check runs first and reflects
  // the previously driven cnt, so the outputs seen belong to cycle cnt = c.
  task automatic cycle(input int sel, input int c, input logic [7:0] d, input logic r);
    int         n;
    logic [7:0] mask;
    logic [7:0] exp_d;
    logic [7:0] obs_d;
    int         exp_v;
    int         obs_v;
    n    = (sel != 0) ? 16 : 8;
    mask = (sel != 0) ? 8'hFF : 8'h07;
    @(negedge clk);
    if (c == 0) begin
      ready[sel]   = pending[sel];
      pending[sel] = 0;
    end
    exp_v = (ready[sel] != 0 && c >= n / 2 && cur_rst[sel] == 0) ? 1 : 0;
    exp_d = '0;
    if (exp_v != 0) begin
      if (sel != 0) begin
        if (q_b.size() > 0) exp_d = q_b.pop_front();
      end else begin
        if (q_a.size() > 0) exp_d = q_a.pop_front();
      end
    end
    obs_d = (sel != 0) ? dout_b : {5'b0, dout_a};
    obs_v = (sel != 0) ? int'(vld_b) : int'(vld_a);
    chk($sformatf("vld%0d cnt=%0d", sel, c), obs_v, exp_v);
    chk($sformatf("dout%0d cnt=%0d", sel, c), int'(obs_d), int'(exp_d));

    if (sel != 0) begin
      cnt_b = 4'(c); din_b = d; rst_b = r;
    end else begin
      cnt_a = 3'(c); din_a = 3'(d & mask); rst_a = r;
    end

    if (r) begin
      // The reset is asynchronous, so the outputs must clear before any clock edge.
      if (cur_rst[sel] == 0) begin
        #1;
        obs_d = (sel != 0) ? dout_b : {5'b0, dout_a};
        obs_v = (sel != 0) ? int'(vld_b) : int'(vld_a);
        chk($sformatf("rst_vld%0d", sel), obs_v, 0);
        chk($sformatf("rst_dout%0d", sel), int'(obs_d), 0);
      end
      cur_rst[sel] = 1;
      cap_ok[sel]  = 0;
      pending[sel] = 0;
      ready[sel]   = 0;
      if (sel != 0) q_b.delete(); else q_a.delete();
    end else begin
      cur_rst[sel] = 0;
      if (c == 0) cap_ok[sel] = 1;
      if (cap_ok[sel] != 0 && (c % 2) == 1) stage[sel][c / 2] = d & mask;
      if (cap_ok[sel] != 0 && c == n - 1) begin
        for (int i = 0; i < n / 2; i++) begin
          if (sel != 0) q_b.push_back(stage[sel][i]);
          else          q_a.push_back(stage[sel][i]);
        end
        pending[sel] = 1;
      end
    end
  endtask

  // One full frame. The odd cycles carry pat[k]. The even cycles carry ev,
  // or random data when ev < 0.
  task automatic frame(input int sel, input int ev);
    int         n;
    logic [7:0] d;
    n = (sel != 0) ? 16 : 8;
    for (int c = 0; c < n; c++) begin
      if ((c % 2) == 1) d = pat[c / 2];
      else if (ev < 0)  d = 8'($urandom);
      else              d = 8'(ev);
      cycle(sel, c, d, 1'b0);
    end
  endtask

  task automatic set_pat(input int p0, input int p1, input int p2, input int p3,
                         input int p4, input int p5, input int p6, input int p7);
    pat[0] = 8'(p0); pat[1] = 8'(p1); pat[2] = 8'(p2); pat[3] = 8'(p3);
    pat[4] = 8'(p4); pat[5] = 8'(p5); pat[6] = 8'(p6); pat[7] = 8'(p7);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset dout_a", int'(dout_a), 0);
    chk("reset vld_a", int'(vld_a), 0);
    chk("reset dout_b", int'(dout_b), 0);
    chk("reset vld_b", int'(vld_b), 0);

    // Instance a: reset is released mid-frame, before cnt=0.
    cycle(0, 5, 8'd3, 1'b1);
    cycle(0, 6, 8'd5, 1'b0);
    cycle(0, 7, 8'd6, 1'b0);
    set_pat(1, 2, 3, 4, 0, 0, 0, 0); frame(0, -1);
    set_pat(5, 6, 7, 0, 0, 0, 0, 0); frame(0, -1);
    set_pat(1, 1, 2, 3, 0, 0, 0, 0); frame(0, -1);
    set_pat(6, 5, 4, 3, 0, 0, 0, 0); frame(0, -1);
    set_pat(2, 1, 2, 3, 0, 0, 0, 0); frame(0, 7);   // even cycles drive 7
    // Reset is asserted at cnt=5 of a replay frame and released at cnt=2.
    for (int c = 0; c < 5; c++) cycle(0, c, 8'($urandom), 1'b0);
    for (int c = 5; c < 8; c++) cycle(0, c, 8'($urandom), 1'b1);
    for (int c = 0; c < 2; c++) cycle(0, c, 8'($urandom), 1'b1);
    for (int c = 2; c < 8; c++) cycle(0, c, 8'($urandom), 1'b0);
    set_pat(4, 3, 2, 1, 0, 0, 0, 0); frame(0, -1);
    set_pat(0, 7, 0, 7, 0, 0, 0, 0); frame(0, -1);
    set_pat(0, 0, 0, 0, 0, 0, 0, 0); frame(0, -1);

    // Instance b, N=16.
    cycle(1, 13, 8'h00, 1'b1);
    cycle(1, 14, 8'h00, 1'b1);
    cycle(1, 15, 8'h00, 1'b0);
    set_pat(8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17); frame(1, -1);
    for (int i = 0; i < 8; i++) pat[i] = 8'($urandom);
    frame(1, -1);
    set_pat(0, 0, 0, 0, 0, 0, 0, 0); frame(1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/doublerate.md
Name: doublerate

Overview:
- Rate-doubling reorder buffer for the FFT datapath.
- Accepts one sample per two clocks across a full frame of N = 2^CBW cycles, indexed by an externally supplied frame counter.
- Replays that frame's N/2 samples back-to-back at full rate during the second half of the following frame.
- Uses a ping-pong pair of banks so capture and replay overlap without corruption.

Parameters:
- DBW, 3, data width in bits.
- CBW, 3, frame counter width; N = 2^CBW cycles per frame, N/2 samples per frame; CBW >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cnt  input  CBW  frame cycle index. Upstream increments it by 1 every clock, modulo N.
- din  input  DBW  half-rate sample. Sample k of a frame is presented at cnt = 2k and 2k+1.
- dout  output  DBW  full-rate replayed sample, registered.
- dout_vld  output  1  high on cycles where dout carries a replayed sample, registered.

Behaviour:
- Storage: 2 banks × N/2 entries × DBW bits, with synchronous write and registered read.

Reset (asynchronous, takes effect immediately while rst=1):
- dout=0, dout_vld=0, wr_bank=0, armed=0, rd_ok=0.
- Memory contents are not cleared; they are never exposed while rd_ok=0.

armed flag:
- Set on the first edge where cnt==0 after reset.
- Cleared only by reset.
- Prevents a partial frame captured after reset from ever being replayed.

Capture:
- On an edge with armed=1 and cnt[0]=1, write din into bank wr_bank at address cnt[CBW-1:1].
- Only the odd-cycle value is stored; the value on even cycles is ignored.

Bank swap, on the edge with cnt==N-1 and armed=1:
- The write of sample N/2-1 uses the old wr_bank.
- wr_bank toggles.
- rd_ok is set to 1.
- When armed=0 at cnt==N-1, nothing toggles and rd_ok stays 0.

Replay read:
- On edges with N/2-1 <= cnt <= N-2, read bank ~wr_bank at address j = cnt-(N/2-1).
- dout <= mem[~wr_bank][j], and dout_vld <= rd_ok.
- On all other edges: dout <= 0 and dout_vld <= 0.
- dout is therefore 0 whenever dout_vld=0.

Latency and valid window:
- Sample j captured in frame f (cnt=2j+1) appears on dout during frame f+1 at cnt = N/2+j.
- dout_vld is high exactly for cnt = N/2 .. N-1 of every frame that follows a complete captured frame.

Boundary conditions:
- No read/write conflict: reads and writes always target opposite banks within a frame.
- The read at cnt=N-2 precedes the toggle at cnt=N-1.
- Continuous operation: consecutive frames alternate banks indefinitely, with no gap in the valid windows.
- Reset mid-frame: outputs go to 0 at once.
  - After release, the first full frame starting at cnt==0 is captured.
  - The first dout_vld occurs at cnt=N/2 of the frame after that one.
- A cnt discontinuity without reset is out of contract; behaviour is undefined.

Test Plan:
1. Reset, N=8 → dout=0 and dout_vld=0 throughout the first frame after release, for any din.
2. CBW=3: release rst before cnt=0, feed samples 1,2,3,4 (each held 2 cycles) in frame 0 → frame 1 dout = 1,2,3,4 at cnt 4,5,6,7 with dout_vld=1; cnt 0..3 show dout=0, dout_vld=0.
3. Back-to-back frames A=5,6,7,0 then B=1,1,2,3 then C=6,5,4,3 → replayed A, B, C in order in consecutive frames; no mixing of banks.
4. din changes on even cycles: drive 7 at cnt=0 and 2 at cnt=1 → only 2 is stored and replayed as sample 0.
5. Assert rst at cnt=5 of a replay frame and release it at cnt=2 → dout and dout_vld drop immediately. The partial frame is discarded; the next frame from cnt=0 is captured and replayed one frame later.
6. CBW=4, DBW=8: feed 8 samples 0x10..0x17 → replayed at cnt 8..15 of the next frame, with dout_vld high only there.
